// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs, decode helper and E-register
// bubble values.
package y86_pkg;

   typedef enum logic [3:0] {
      I_HALT   = 4'h0,
      I_NOP    = 4'h1,
      I_RRMOVQ = 4'h2,
      I_IRMOVQ = 4'h3,
      I_RMMOVQ = 4'h4,
      I_MRMOVQ = 4'h5,
      I_OPQ    = 4'h6,
      I_JXX    = 4'h7,
      I_CALL   = 4'h8,
      I_RET    = 4'h9,
      I_PUSHQ  = 4'hA,
      I_POPQ   = 4'hB
   } icode_e;

   localparam logic [3:0] R_RSP  = 4'h4;
   localparam logic [3:0] R_NONE = 4'hF;

   typedef struct packed {
      logic [3:0] src_a;
      logic [3:0] src_b;
      logic [3:0] dst_e;
      logic [3:0] dst_m;
   } reg_ids_t;

   localparam reg_ids_t   IDS_NONE     = '{R_NONE, R_NONE, R_NONE, R_NONE};
   localparam logic [3:0] BUBBLE_ICODE = I_NOP;
   localparam logic [3:0] BUBBLE_IFUN  = 4'h0;

   // cmov keeps its dstE here; the condition is resolved in execute.
   function automatic reg_ids_t decode_ids(input logic       valid,
                                           input logic [3:0] icode,
                                           input logic [3:0] ra,
                                           input logic [3:0] rb);
      reg_ids_t ids;
      ids = IDS_NONE;
      if (valid) begin
         case (icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: ids.src_a = ra;
            I_RET, I_POPQ:                      ids.src_a = R_RSP;
            default:                            ids.src_a = R_NONE;
         endcase
         case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:            ids.src_b = rb;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:       ids.src_b = R_RSP;
            default:                              ids.src_b = R_NONE;
         endcase
         case (icode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:            ids.dst_e = rb;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:       ids.dst_e = R_RSP;
            default:                              ids.dst_e = R_NONE;
         endcase
         case (icode)
            I_MRMOVQ, I_POPQ: ids.dst_m = ra;
            default:          ids.dst_m = R_NONE;
         endcase
      end
      return ids;
   endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15-entry register file: two write ports (M beats E on a shared destination), two read ports
// with write-through bypass from the same-cycle writes, and an unbypassed debug port.
module y86_regfile
   import y86_pkg::*;
#(
   parameter int unsigned      WIDTH    = 64,
   parameter logic [WIDTH-1:0] RSP_INIT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       src_a,
   input  logic [3:0]       src_b,
   input  logic [3:0]       dst_e,
   input  logic [WIDTH-1:0] val_e,
   input  logic [3:0]       dst_m,
   input  logic [WIDTH-1:0] val_m,
   input  logic [3:0]       dbg_addr,
   output logic [WIDTH-1:0] rd_a,
   output logic [WIDTH-1:0] rd_b,
   output logic [WIDTH-1:0] dbg_data
);

   logic [WIDTH-1:0] regs_q [15];
   logic [WIDTH-1:0] regs_d [15];

   function automatic logic [WIDTH-1:0] bypass_read(input logic [3:0] src);
      logic [WIDTH-1:0] v;
      if (src == R_NONE)      v = '0;
      else if (src == dst_m)  v = val_m;
      else if (src == dst_e)  v = val_e;
      else                    v = regs_q[src];
      return v;
   endfunction

   always_comb begin
      regs_d = regs_q;
      if (dst_e != R_NONE) regs_d[dst_e] = val_e;
      // Applied second so popq %rsp keeps the loaded value.
      if (dst_m != R_NONE) regs_d[dst_m] = val_m;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 15; i++) regs_q[i] <= '0;
         regs_q[R_RSP] <= RSP_INIT;
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rd_a     = bypass_read(src_a);
      rd_b     = bypass_read(src_b);
      dbg_data = (dbg_addr == R_NONE) ? '0 : regs_q[dbg_addr];
   end

endmodule

// File: rtl/decode_regread_pipe.sv
// Y86-64 decode/register-read stage: decodes register IDs from D, reads bypassed operands and
// registers them into the E pipeline register under stall/bubble control.
module decode_regread_pipe
   import y86_pkg::*;
#(
   parameter int unsigned      WIDTH    = 64,
   parameter logic [WIDTH-1:0] RSP_INIT = 64'h0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             D_valid,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       D_ifun,
   input  logic [3:0]       D_rA,
   input  logic [3:0]       D_rB,
   input  logic [WIDTH-1:0] D_valC,
   input  logic [WIDTH-1:0] D_valP,
   input  logic             E_stall,
   input  logic             E_bubble,
   input  logic [3:0]       W_dstE,
   input  logic [WIDTH-1:0] W_valE,
   input  logic [3:0]       W_dstM,
   input  logic [WIDTH-1:0] W_valM,
   output logic             E_valid,
   output logic [3:0]       E_icode,
   output logic [3:0]       E_ifun,
   output logic [WIDTH-1:0] E_valC,
   output logic [WIDTH-1:0] E_valA,
   output logic [WIDTH-1:0] E_valB,
   output logic [3:0]       E_srcA,
   output logic [3:0]       E_srcB,
   output logic [3:0]       E_dstE,
   output logic [3:0]       E_dstM,
   input  logic [3:0]       dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   reg_ids_t         d_ids;
   logic [WIDTH-1:0] rd_a, rd_b, sel_val_a;

   logic             e_valid_q, e_valid_d;
   logic [3:0]       e_icode_q, e_icode_d;
   logic [3:0]       e_ifun_q, e_ifun_d;
   logic [WIDTH-1:0] e_valc_q, e_valc_d;
   logic [WIDTH-1:0] e_vala_q, e_vala_d;
   logic [WIDTH-1:0] e_valb_q, e_valb_d;
   reg_ids_t         e_ids_q, e_ids_d;

   always_comb begin
      d_ids = decode_ids(D_valid, D_icode, D_rA, D_rB);
   end

   y86_regfile #(
      .WIDTH    (WIDTH),
      .RSP_INIT (RSP_INIT)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .src_a    (d_ids.src_a),
      .src_b    (d_ids.src_b),
      .dst_e    (W_dstE),
      .val_e    (W_valE),
      .dst_m    (W_dstM),
      .val_m    (W_valM),
      .dbg_addr (dbg_addr),
      .rd_a     (rd_a),
      .rd_b     (rd_b),
      .dbg_data (dbg_data)
   );

   // jXX and call carry the fall-through PC in valA instead of a register.
   always_comb begin
      sel_val_a = rd_a;
      if (D_icode == I_JXX || D_icode == I_CALL) sel_val_a = D_valP;
   end

   always_comb begin
      e_valid_d = e_valid_q;
      e_icode_d = e_icode_q;
      e_ifun_d  = e_ifun_q;
      e_valc_d  = e_valc_q;
      e_vala_d  = e_vala_q;
      e_valb_d  = e_valb_q;
      e_ids_d   = e_ids_q;
      if (E_bubble) begin
         e_valid_d = 1'b0;
         e_icode_d = BUBBLE_ICODE;
         e_ifun_d  = BUBBLE_IFUN;
         e_valc_d  = '0;
         e_vala_d  = '0;
         e_valb_d  = '0;
         e_ids_d   = IDS_NONE;
      end else if (!E_stall) begin
         e_valid_d = D_valid;
         e_icode_d = D_icode;
         e_ifun_d  = D_ifun;
         e_valc_d  = D_valC;
         e_vala_d  = sel_val_a;
         e_valb_d  = rd_b;
         e_ids_d   = d_ids;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         e_valid_q <= 1'b0;
         e_icode_q <= BUBBLE_ICODE;
         e_ifun_q  <= BUBBLE_IFUN;
         e_valc_q  <= '0;
         e_vala_q  <= '0;
         e_valb_q  <= '0;
         e_ids_q   <= IDS_NONE;
      end else begin
         e_valid_q <= e_valid_d;
         e_icode_q <= e_icode_d;
         e_ifun_q  <= e_ifun_d;
         e_valc_q  <= e_valc_d;
         e_vala_q  <= e_vala_d;
         e_valb_q  <= e_valb_d;
         e_ids_q   <= e_ids_d;
      end
   end

   always_comb begin
      E_valid = e_valid_q;
      E_icode = e_icode_q;
      E_ifun  = e_ifun_q;
      E_valC  = e_valc_q;
      E_valA  = e_vala_q;
      E_valB  = e_valb_q;
      E_srcA  = e_ids_q.src_a;
      E_srcB  = e_ids_q.src_b;
      E_dstE  = e_ids_q.dst_e;
      E_dstM  = e_ids_q.dst_m;
   end

endmodule

// File: tb/tb_decode_regread_pipe.sv
// Directed bench for decode_regread_pipe with hand-computed expectations.
module tb_decode_regread_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        D_valid;
   logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
   logic [63:0] D_valC, D_valP;
   logic        E_stall, E_bubble;
   logic [3:0]  W_dstE, W_dstM;
   logic [63:0] W_valE, W_valM;
   logic        E_valid;
   logic [3:0]  E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM;
   logic [63:0] E_valC, E_valA, E_valB;
   logic [3:0]  dbg_addr;
   logic [63:0] dbg_data;

   int n_cmp = 0;
   int n_err = 0;

   decode_regread_pipe #(
      .WIDTH    (64),
      .RSP_INIT (64'h100)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .D_valid  (D_valid),
      .D_icode  (D_icode),
      .D_ifun   (D_ifun),
      .D_rA     (D_rA),
      .D_rB     (D_rB),
      .D_valC   (D_valC),
      .D_valP   (D_valP),
      .E_stall  (E_stall),
      .E_bubble (E_bubble),
      .W_dstE   (W_dstE),
      .W_valE   (W_valE),
      .W_dstM   (W_dstM),
      .W_valM   (W_valM),
      .E_valid  (E_valid),
      .E_icode  (E_icode),
      .E_ifun   (E_ifun),
      .E_valC   (E_valC),
      .E_valA   (E_valA),
      .E_valB   (E_valB),
      .E_srcA   (E_srcA),
      .E_srcB   (E_srcB),
      .E_dstE   (E_dstE),
      .E_dstM   (E_dstM),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always #50 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic dbg_chk(input string tag, input logic [3:0] a, input logic [63:0] exp);
      dbg_addr = a;
      #1;
      chk(tag, dbg_data, exp);
   endtask

   task automatic set_d(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] c, input logic [63:0] p);
      D_valid = v; D_icode = ic; D_ifun = fn; D_rA = ra; D_rB = rb; D_valC = c; D_valP = p;
   endtask

   task automatic set_w(input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm);
      W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
   endtask

   initial begin
      rst_n = 1'b0; E_stall = 1'b0; E_bubble = 1'b0; dbg_addr = 4'h0;
      set_d(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
      set_w(4'hF, 64'h0, 4'hF, 64'h0);
      step(); step();

      // Reset state
      for (int i = 0; i < 16; i++)
         dbg_chk("rst_reg", 4'(i), (i == 4) ? 64'h100 : 64'h0);
      chk4("rst_icode", E_icode, 4'h1);
      chk1("rst_valid", E_valid, 1'b0);
      chk4("rst_dstE", E_dstE, 4'hF);
      chk4("rst_srcA", E_srcA, 4'hF);
      chk("rst_valA", E_valA, 64'h0);

      // Write reg3 then read it through opq
      rst_n = 1'b1;
      set_w(4'h3, 64'h5, 4'hF, 64'h0);
      step();
      set_w(4'hF, 64'h0, 4'hF, 64'h0);
      set_d(1'b1, 4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h0);
      step();
      chk("opq_valA", E_valA, 64'h5);
      chk("opq_valB", E_valB, 64'h5);
      chk4("opq_dstE", E_dstE, 4'h3);
      chk4("opq_srcA", E_srcA, 4'h3);
      chk4("opq_dstM", E_dstM, 4'hF);
      dbg_chk("opq_reg3", 4'h3, 64'h5);

      // Same-cycle M bypass over an older reg2 value
      set_w(4'h2, 64'h11, 4'hF, 64'h0);
      step();
      set_w(4'hF, 64'h0, 4'h2, 64'hAA);
      set_d(1'b1, 4'h4, 4'h0, 4'h2, 4'h3, 64'h18, 64'h0);
      step();
      chk("byp_valA", E_valA, 64'hAA);
      chk("byp_valB", E_valB, 64'h5);
      chk("byp_valC", E_valC, 64'h18);
      chk4("byp_srcB", E_srcB, 4'h3);
      chk4("byp_dstE", E_dstE, 4'hF);
      dbg_chk("byp_reg2", 4'h2, 64'hAA);

      // Both W ports to %rsp with popq in D
      set_w(4'h4, 64'h10, 4'h4, 64'h20);
      set_d(1'b1, 4'hB, 4'h0, 4'h5, 4'hF, 64'h0, 64'h0);
      step();
      dbg_chk("pop_reg4", 4'h4, 64'h20);
      chk4("pop_srcA", E_srcA, 4'h4);
      chk4("pop_srcB", E_srcB, 4'h4);
      chk4("pop_dstE", E_dstE, 4'h4);
      chk4("pop_dstM", E_dstM, 4'h5);
      chk("pop_valA", E_valA, 64'h20);
      chk("pop_valB", E_valB, 64'h20);

      // call: valA from valP
      set_w(4'hF, 64'h0, 4'hF, 64'h0);
      set_d(1'b1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h77, 64'h40);
      step();
      chk("call_valA", E_valA, 64'h40);
      chk("call_valB", E_valB, 64'h20);
      chk4("call_srcA", E_srcA, 4'hF);
      chk4("call_srcB", E_srcB, 4'h4);
      chk4("call_dstE", E_dstE, 4'h4);
      chk4("call_dstM", E_dstM, 4'hF);

      // Stall two cycles: E holds, regfile still written
      E_stall = 1'b1;
      set_d(1'b1, 4'h3, 4'h0, 4'hF, 4'h7, 64'h99, 64'h0);
      set_w(4'h6, 64'h66, 4'hF, 64'h0);
      step();
      chk4("stl1_icode", E_icode, 4'h8);
      chk("stl1_valA", E_valA, 64'h40);
      chk4("stl1_dstE", E_dstE, 4'h4);
      set_w(4'h9, 64'h99, 4'hF, 64'h0);
      step();
      chk4("stl2_icode", E_icode, 4'h8);
      chk("stl2_valC", E_valC, 64'h77);
      dbg_chk("stl_reg6", 4'h6, 64'h66);
      dbg_chk("stl_reg9", 4'h9, 64'h99);

      // Bubble beats stall
      set_w(4'hF, 64'h0, 4'hF, 64'h0);
      E_bubble = 1'b1;
      step();
      chk1("bub_valid", E_valid, 1'b0);
      chk4("bub_icode", E_icode, 4'h1);
      chk4("bub_dstE", E_dstE, 4'hF);
      chk("bub_valA", E_valA, 64'h0);
      chk("bub_valC", E_valC, 64'h0);

      // Release: irmovq loads
      E_stall = 1'b0; E_bubble = 1'b0;
      step();
      chk1("irm_valid", E_valid, 1'b1);
      chk4("irm_dstE", E_dstE, 4'h7);
      chk4("irm_srcA", E_srcA, 4'hF);
      chk("irm_valA", E_valA, 64'h0);
      chk("irm_valC", E_valC, 64'h99);

      // Unknown icode
      set_d(1'b1, 4'hC, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
      step();
      chk4("unk_srcA", E_srcA, 4'hF);
      chk4("unk_dstE", E_dstE, 4'hF);
      chk4("unk_icode", E_icode, 4'hC);
      chk1("unk_valid", E_valid, 1'b1);

      // D_valid=0 forces IDs to F
      set_d(1'b0, 4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h0);
      step();
      chk4("inv_srcA", E_srcA, 4'hF);
      chk4("inv_dstE", E_dstE, 4'hF);
      chk("inv_valA", E_valA, 64'h0);
      chk1("inv_valid", E_valid, 1'b0);

      // cmov keeps dstE
      set_d(1'b1, 4'h2, 4'h3, 4'h6, 4'h1, 64'h0, 64'h0);
      step();
      chk4("cmov_dstE", E_dstE, 4'h1);
      chk4("cmov_ifun", E_ifun, 4'h3);
      chk("cmov_valA", E_valA, 64'h66);

      // Mid-operation reset drops the pending write
      rst_n = 1'b0;
      set_w(4'h3, 64'hDEAD, 4'hF, 64'h0);
      step();
      dbg_chk("mrst_reg3", 4'h3, 64'h0);
      dbg_chk("mrst_reg4", 4'h4, 64'h100);
      dbg_chk("mrst_regF", 4'hF, 64'h0);
      chk1("mrst_valid", E_valid, 1'b0);
      chk4("mrst_dstE", E_dstE, 4'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
